// File: rtl/wrr_arb_pkg.sv
// Shared types and helpers for the weighted round-robin arbiter.
package wrr_arb_pkg;

  typedef enum logic {
    StIdle  = 1'b0,
    StGrant = 1'b1
  } state_e;

  localparam int unsigned DefaultN  = 4;
  localparam int unsigned DefaultWw = 3;

  // A programmed quantum of zero still grants one cycle.
  function automatic int unsigned eff_weight(input int unsigned w);
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating priority encoder: first set request bit at or above
// the pointer, wrapping modulo N.
module rr_pick #(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = 2
) (
  input  logic [N-1:0]   i_request,
  input  logic [IDW-1:0] i_pointer,
  output logic [IDW-1:0] o_winner,
  output logic           o_any_req
);

  always_comb begin
    o_winner  = '0;
    o_any_req = 1'b0;
    for (int k = 0; k < int'(N); k++) begin
      int idx;
      idx = int'(i_pointer) + k;
      if (idx >= int'(N)) idx = idx - int'(N);
      if (!o_any_req && i_request[idx]) begin
        o_any_req = 1'b1;
        o_winner  = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/weighted_rr_arbiter.sv
// Weighted round-robin arbiter with registered one-hot grant.
// Optional WRR_LOCK_EN adds a lock input that holds the grant past quantum expiry.
module weighted_rr_arbiter
  import wrr_arb_pkg::*;
#(
  parameter int unsigned N   = DefaultN,
  parameter int unsigned WW  = DefaultWw,
  parameter int unsigned IDW = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [N-1:0]    request,
  input  logic [N*WW-1:0] weight_cfg,
`ifdef WRR_LOCK_EN
  input  logic [N-1:0]    lock,
`endif
  output logic [N-1:0]    grant,
  output logic            grant_valid,
  output logic [IDW-1:0]  grant_id
);

  state_e         r_state;
  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] r_grant_id;
  logic [N-1:0]   r_grant;
  logic           r_grant_valid;
  logic [WW-1:0]  r_remaining;

  logic           w_own_req;
  logic           w_lock_hold;
  logic           w_tenure_end;
  logic [IDW-1:0] w_next_ptr;
  logic [IDW-1:0] w_pick_ptr;
  logic [IDW-1:0] w_winner;
  logic           w_any_req;
  logic [WW-1:0]  w_win_weight;
  logic [WW-1:0]  w_win_quantum;
  logic [N-1:0]   w_win_onehot;

  assign w_own_req = request[r_grant_id];

`ifdef WRR_LOCK_EN
  assign w_lock_hold = lock[r_grant_id] & w_own_req;
`else
  assign w_lock_hold = 1'b0;
`endif

  assign w_tenure_end = (r_state == StGrant) &&
                        (!w_own_req || ((r_remaining <= WW'(1)) && !w_lock_hold));

  assign w_next_ptr = (r_grant_id == IDW'(N - 1)) ? '0 : r_grant_id + 1'b1;

  // Re-arbitration at tenure end searches from the advanced pointer on the same edge.
  assign w_pick_ptr = w_tenure_end ? w_next_ptr : r_ptr;

  rr_pick #(
    .N  (N),
    .IDW(IDW)
  ) u_rr_pick (
    .i_request(request),
    .i_pointer(w_pick_ptr),
    .o_winner (w_winner),
    .o_any_req(w_any_req)
  );

  assign w_win_weight  = weight_cfg[w_winner*WW +: WW];
  assign w_win_quantum = WW'(eff_weight(32'(w_win_weight)));
  assign w_win_onehot  = {{(N-1){1'b0}}, 1'b1} << w_winner;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= StIdle;
      r_ptr         <= '0;
      r_grant_id    <= '0;
      r_grant       <= '0;
      r_grant_valid <= 1'b0;
      r_remaining   <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_any_req) begin
            r_state       <= StGrant;
            r_grant       <= w_win_onehot;
            r_grant_id    <= w_winner;
            r_grant_valid <= 1'b1;
            r_remaining   <= w_win_quantum;
          end
        end
        StGrant: begin
          if (w_tenure_end) begin
            r_ptr <= w_next_ptr;
            if (w_any_req) begin
              r_grant     <= w_win_onehot;
              r_grant_id  <= w_winner;
              r_remaining <= w_win_quantum;
            end else begin
              r_state       <= StIdle;
              r_grant       <= '0;
              r_grant_id    <= '0;
              r_grant_valid <= 1'b0;
              r_remaining   <= '0;
            end
          end else if (r_remaining > WW'(1)) begin
            r_remaining <= r_remaining - 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign grant       = r_grant;
  assign grant_valid = r_grant_valid;
  assign grant_id    = r_grant_id;

endmodule
